// File: rtl/sample_decim_fifo.sv
// sample_decim_fifo: keeps 1 of (decim_factor+1) samples, packs sample pairs into 32-bit words, and buffers the words in a FIFO.
module sample_decim_fifo #(
  parameter int DEPTH = 64,
  parameter int LVL_W = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               signal_valid,
  input  logic signed [15:0] signal,
  input  logic               enable,
  input  logic               clear,
  input  logic [3:0]         decim_factor,
  input  logic               rd_en,
  output logic [31:0]        rd_data,
  output logic               rd_valid,
  output logic [LVL_W-1:0]   level,
  output logic               empty,
  output logic               full,
  output logic               overflow
);
  localparam int AW = LVL_W - 1;
  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [LVL_W-1:0] r_level;
  logic [3:0]       r_dcnt;
  logic             r_half, r_ovf, r_rd_valid;
  logic [15:0]      r_lo;
  logic [31:0]      r_rd_data;
  logic             w_acc, w_keep, w_wr, w_rd, w_push, w_pop;
  assign w_acc    = signal_valid & enable;
  assign w_keep   = w_acc & (r_dcnt == 4'd0);
  assign w_wr     = w_keep & r_half;
  assign w_rd     = rd_en & ~empty;
  assign w_push   = w_wr & (~full | w_rd) & ~clear;
  assign w_pop    = w_rd & ~clear;
  assign empty    = r_level == '0;
  assign full     = r_level == LVL_W'(DEPTH);
  assign level    = r_level;
  assign overflow = r_ovf;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= {signal, r_lo};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_dcnt     <= '0;
      r_half     <= 1'b0;
      r_lo       <= '0;
      r_ovf      <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_dcnt     <= '0;
      r_half     <= 1'b0;
      r_ovf      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop;
      r_level    <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      if (w_pop) begin
        r_rd_data <= r_mem[r_rptr];
        r_rptr    <= r_rptr + AW'(1);
      end
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_wr && full && !w_rd) r_ovf <= 1'b1;
      if (w_acc) r_dcnt <= (r_dcnt >= decim_factor) ? 4'd0 : r_dcnt + 4'd1;
      if (w_keep) r_half <= ~r_half;
      if (w_keep && !r_half) r_lo <= signal;
    end
  end
endmodule

// File: tb/tb_sample_decim_fifo.sv
// tb_sample_decim_fifo: randomized and directed checking of sample_decim_fifo against a queue-based model.
module tb_sample_decim_fifo;
  localparam int DEPTH = 64;
  localparam int LVL_W = 7;
  logic clk = 0, rst_n = 0, signal_valid = 0, enable = 0, clear = 0, rd_en = 0;
  logic signed [15:0] sig = 0;
  logic [3:0] decim = 0;
  logic [31:0] rd_data;
  logic rd_valid, empty, full, overflow;
  logic [LVL_W-1:0] level;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  logic [3:0] m_dcnt;
  logic m_half, m_ovf, m_rv;
  logic [15:0] m_lo;
  logic [31:0] m_rd;

  sample_decim_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst_n(rst_n), .signal_valid(signal_valid), .signal(sig),
    .enable(enable), .clear(clear), .decim_factor(decim), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .empty(empty),
    .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("level", 32'(level), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("rd_data", rd_data, m_rd);
  endtask

  task automatic model_reset();
    q.delete();
    m_dcnt = 0; m_half = 0; m_lo = 0; m_ovf = 0; m_rv = 0; m_rd = 0;
  endtask

  task automatic model_step();
    logic was_full, rd;
    if (clear) begin
      q.delete();
      m_dcnt = 0; m_half = 0; m_ovf = 0; m_rv = 0;
    end else begin
      was_full = q.size() == DEPTH;
      rd = rd_en && q.size() != 0;
      m_rv = rd;
      if (rd) m_rd = q.pop_front();
      if (signal_valid && enable) begin
        if (m_dcnt == 0) begin
          if (m_half) begin
            if (was_full && !rd) m_ovf = 1;
            else q.push_back({sig, m_lo});
            m_half = 0;
          end else begin
            m_lo = sig;
            m_half = 1;
          end
        end
        m_dcnt = (m_dcnt >= decim) ? 4'd0 : m_dcnt + 4'd1;
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [15:0] s, input logic en, input logic rd, input logic clr);
    signal_valid = v; sig = s; enable = en; rd_en = rd; clear = clr;
    @(posedge clk);
    model_step();
    #1 compare();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    model_reset();
    compare();
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic push_samples(input int n, input int base);
    for (int i = 0; i < n; i++) cyc(1, 16'(base + i), 1, 0, 0);
  endtask

  initial begin
    model_reset();
    #1 do_reset();
    chk("reset_level", 32'(level), 32'h0);
    chk("reset_ovf", 32'(overflow), 32'h0);
    decim = 0;
    cyc(1, 16'h0001, 1, 0, 0);
    cyc(1, 16'hFFFE, 1, 0, 0);
    cyc(1, 16'h1234, 1, 0, 0);
    cyc(1, 16'h8000, 1, 0, 0);
    chk("d39_level", 32'(level), 32'd2);
    cyc(0, 0, 1, 1, 0);
    chk("d39_word0", rd_data, 32'hFFFE0001);
    chk("d39_valid0", 32'(rd_valid), 32'h1);
    cyc(0, 0, 1, 1, 0);
    chk("d39_word1", rd_data, 32'h80001234);
    cyc(0, 0, 1, 0, 0);
    chk("d39_valid_drop", 32'(rd_valid), 32'h0);
    cyc(0, 0, 1, 1, 0);
    chk("d43_valid", 32'(rd_valid), 32'h0);
    chk("d43_hold", rd_data, 32'h80001234);
    decim = 3;
    push_samples(16, 0);
    chk("d40_level", 32'(level), 32'd2);
    cyc(0, 0, 1, 1, 0);
    chk("d40_word0", rd_data, 32'h00040000);
    cyc(0, 0, 1, 1, 0);
    chk("d40_word1", rd_data, 32'h000C0008);
    decim = 0;
    push_samples(130, 0);
    chk("d41_level", 32'(level), 32'd64);
    chk("d41_full", 32'(full), 32'h1);
    chk("d41_ovf", 32'(overflow), 32'h1);
    cyc(0, 0, 1, 1, 0);
    chk("d41_first", rd_data, 32'h00010000);
    cyc(0, 0, 1, 0, 0);
    chk("d41_sticky", 32'(overflow), 32'h1);
    cyc(0, 0, 1, 0, 1);
    chk("d41_cleared", 32'(overflow), 32'h0);
    push_samples(128, 0);
    cyc(1, 16'h7777, 1, 0, 0);
    cyc(1, 16'h6666, 1, 1, 0);
    chk("d42_level", 32'(level), 32'd64);
    chk("d42_ovf", 32'(overflow), 32'h0);
    chk("d42_oldest", rd_data, 32'h00010000);
    cyc(1, 16'h1111, 1, 0, 0);
    cyc(0, 0, 1, 0, 1);
    cyc(1, 16'h2222, 1, 0, 0);
    do_reset();
    cyc(1, 16'hAAAA, 1, 0, 0);
    cyc(1, 16'h5555, 1, 0, 0);
    chk("d44_level", 32'(level), 32'd1);
    cyc(0, 0, 1, 1, 0);
    chk("d44_word", rd_data, 32'h5555AAAA);
    cyc(1, 16'h0101, 1, 0, 0);
    cyc(1, 16'h0202, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 16'h0303, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    chk("d33_word", rd_data, 32'h03030101);
    for (int i = 0; i < 6000; i++) begin
      int rd_pct;
      rd_pct = ((i / 500) % 3 == 0) ? 5 : ((i / 500) % 3 == 1) ? 50 : 90;
      if ($urandom_range(59) == 0) decim = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(2));
      if ($urandom_range(1499) == 0) do_reset();
      cyc($urandom_range(99) < 80, 16'($urandom), $urandom_range(9) != 0,
          $urandom_range(99) < rd_pct, $urandom_range(299) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sample_decim_fifo.md
SAMPLE_DECIM_FIFO -- requirements
Module: sample_decim_fifo

Interface
REQ-001 Parameter DEPTH, default 64: FIFO depth in 32-bit words; power of two, 4..1024.
REQ-002 Parameter LVL_W, default 7: level width; equals log2(DEPTH)+1.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: port clk, input, 1 bit, rising-edge clock; port rst_n, input, 1 bit, asynchronous reset, active low.
REQ-004 Port signal_valid, input, 1 bit: one-cycle qualifier for signal; the FIR filter output valid connects here.
REQ-005 Port signal, input, 16 bits, signed: filtered sample; the FIR filter output connects here.
REQ-006 Port enable, input, 1 bit: accept samples when high.
REQ-007 Port clear, input, 1 bit: synchronous flush pulse.
REQ-008 Port decim_factor, input, 4 bits: keep one sample out of (decim_factor+1).
REQ-009 Port rd_en, input, 1 bit: read request for one word.
REQ-010 Port rd_data, output, 32 bits: read word, {newer sample[31:16], older sample[15:0]}.
REQ-011 Port rd_valid, output, 1 bit: rd_data holds a fresh word.
REQ-012 Port level, output, LVL_W bits: stored word count, range 0..DEPTH.
REQ-013 Port empty, output, 1 bit: high when level==0.
REQ-014 Port full, output, 1 bit: high when level==DEPTH.
REQ-015 Port overflow, output, 1 bit: sticky; high after a word was dropped.

Function
REQ-016 Accepted sample: signal_valid=1 and enable=1 in the same cycle; the block SHALL ignore all other samples.
REQ-017 Decimation counter dcnt (4 bits): on each accepted sample, keep the sample if dcnt==0; then dcnt <= (dcnt>=decim_factor) ? 0 : dcnt+1.
REQ-018 decim_factor=0 SHALL keep every accepted sample; 15 SHALL keep 1 of 16.
REQ-019 A decim_factor change mid-stream SHALL apply from the next accepted sample; if dcnt exceeds the new value, dcnt wraps to 0.
REQ-020 Packing: a kept sample while half=0 SHALL go to hold register lo, then half<=1.
REQ-021 A kept sample while half=1 SHALL write word {sample, lo} to the FIFO at that edge, then half<=0.
REQ-022 A FIFO write SHALL be reflected in level, empty and full on the cycle after the write edge.
REQ-023 Write when full without a simultaneous read: drop the word, set overflow, leave FIFO contents unchanged.
REQ-024 Read: rd_en=1 with empty=0 SHALL pop the oldest word.
REQ-025 A popped word SHALL be driven on rd_data with rd_valid=1 for exactly one cycle, on the cycle after rd_en.
REQ-026 rd_en=1 with empty=1 SHALL have no effect: rd_valid=0, rd_data holds its previous value.
REQ-027 rd_valid=0 SHALL always mean rd_data holds its last value.
REQ-028 Simultaneous write and read with full=1: both succeed, level stays DEPTH, overflow not set.
REQ-029 Simultaneous write and read with empty=1: write succeeds, read ignored, level becomes 1.
REQ-030 Simultaneous write and read otherwise: level unchanged.
REQ-031 clear=1 SHALL zero the pointers, level, dcnt, half and overflow in one cycle.
REQ-032 clear SHALL take priority over any write or read in the same cycle; rd_valid=0 on the following cycle.
REQ-033 enable=0 SHALL hold dcnt, half and lo; a pending lo half-word survives enable toggling.
REQ-034 Pointers SHALL wrap modulo DEPTH; FIFO storage is plain registers or inferred RAM with a registered read.
REQ-035 The block SHALL apply no arithmetic to samples: bit-exact pass-through.

Reset
REQ-036 While rst_n=0, asynchronously: rd_data=0, rd_valid=0, level=0, empty=1, full=0, overflow=0, dcnt=0, half=0, lo=0, pointers=0.
REQ-037 Reset asserted mid-operation SHALL discard all stored and partially packed data; the first kept sample after release goes to lo.
REQ-038 Storage array contents need not be reset.

Verification
REQ-039 decim_factor=0, enable=1, samples 0x0001, 0xFFFE, 0x1234, 0x8000 -> level=2; two reads -> 0xFFFE0001, then 0x80001234, each with a 1-cycle rd_valid.
REQ-040 decim_factor=3, samples 0..15 -> kept 0,4,8,12; words 0x00040000, 0x000C0008; level=2.
REQ-041 DEPTH=64, 130 kept samples with no reads -> level=64, full=1, overflow=1; first read returns the first word; overflow stays 1 until clear.
REQ-042 Full FIFO, rd_en coincident with a packing write -> level stays 64, overflow stays 0, last read word is the oldest one.
REQ-043 rd_en on empty FIFO -> rd_valid=0, rd_data unchanged.
REQ-044 One sample kept (half=1), then clear and rst_n pulse mid-stream -> level=0, overflow=0; the next two samples pack as a fresh word.
